// File: rtl/gpio_native.sv
// gpio_native: memory-mapped GPIO slave for the PicoRV32 native bus.
// Provides output data, per-pin direction, a two-flop input synchronizer
// and atomic set/clear of the output data.
// Optional edge interrupts are built when the macro GPIO_IRQ_EN is defined.
`timescale 1ns/1ps

module gpio_native #(
    parameter int unsigned NGPIO     = 8,
    parameter logic [31:0] OUT_RESET = 32'h0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             mem_valid,
    output logic             mem_ready,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_wdata,
    input  logic [3:0]       mem_wstrb,
    output logic [31:0]      mem_rdata,
    input  logic [NGPIO-1:0] gpio_in,
    output logic [NGPIO-1:0] gpio_out,
    output logic [NGPIO-1:0] gpio_oe,
    output logic             irq
);

    typedef enum logic {StIdle, StAck} state_e;

    state_e           r_state;
    logic             r_ready;
    logic [31:0]      r_rdata;
    logic [NGPIO-1:0] r_data_out;
    logic [NGPIO-1:0] r_dir;
    logic [NGPIO-1:0] r_sync1;
    logic [NGPIO-1:0] r_sync2;

    logic [2:0]  w_off;
    logic        w_wr;
    logic [31:0] w_bmask;
    logic [31:0] w_wval;
    logic [31:0] w_out32;
    logic [31:0] w_dir32;
    logic [31:0] w_in32;
    logic [31:0] w_out_nxt;
    logic [31:0] w_dir_nxt;
    logic [31:0] w_rd;

    assign w_off   = mem_addr[4:2];
    // Writes only land in the idle state; the ACK cycle never samples the bus.
    assign w_wr    = (r_state == StIdle) && mem_valid && (mem_wstrb != 4'b0000);
    assign w_bmask = {{8{mem_wstrb[3]}}, {8{mem_wstrb[2]}}, {8{mem_wstrb[1]}}, {8{mem_wstrb[0]}}};
    assign w_wval  = mem_wdata & w_bmask;

`ifdef GPIO_IRQ_EN
    logic [NGPIO-1:0] r_sync3;
    logic [NGPIO-1:0] r_irq_mask;
    logic [NGPIO-1:0] r_irq_status;
    logic [NGPIO-1:0] r_irq_edge;
    logic             r_irq;
    logic [31:0]      w_mask32;
    logic [31:0]      w_status32;
    logic [31:0]      w_edge32;
    logic [31:0]      w_mask_nxt;
    logic [31:0]      w_edge_nxt;
    logic [NGPIO-1:0] w_event;
    logic [NGPIO-1:0] w_clr;
`endif

    // Zero-extend the pin-wide registers to bus width for read and merge logic.
    always_comb begin
        w_out32 = '0;
        w_dir32 = '0;
        w_in32  = '0;
        w_out32[NGPIO-1:0] = r_data_out;
        w_dir32[NGPIO-1:0] = r_dir;
        w_in32[NGPIO-1:0]  = r_sync2;
`ifdef GPIO_IRQ_EN
        w_mask32   = '0;
        w_status32 = '0;
        w_edge32   = '0;
        w_mask32[NGPIO-1:0]   = r_irq_mask;
        w_status32[NGPIO-1:0] = r_irq_status;
        w_edge32[NGPIO-1:0]   = r_irq_edge;
`endif
    end

    // Next-state of the writable registers, merged byte-wise per strobe.
    always_comb begin
        w_out_nxt = w_out32;
        w_dir_nxt = w_dir32;
`ifdef GPIO_IRQ_EN
        w_mask_nxt = w_mask32;
        w_edge_nxt = w_edge32;
`endif
        if (w_wr) begin
            case (w_off)
                3'd0: w_out_nxt = (w_out32 & ~w_bmask) | w_wval;
                3'd1: w_dir_nxt = (w_dir32 & ~w_bmask) | w_wval;
                3'd3: w_out_nxt = w_out32 | w_wval;
                3'd4: w_out_nxt = w_out32 & ~w_wval;
`ifdef GPIO_IRQ_EN
                3'd5: w_mask_nxt = (w_mask32 & ~w_bmask) | w_wval;
                3'd7: w_edge_nxt = (w_edge32 & ~w_bmask) | w_wval;
`endif
                default: ;
            endcase
        end
    end

    // Read mux; SET/CLR and absent registers read as zero.
    always_comb begin
        w_rd = '0;
        case (w_off)
            3'd0: w_rd = w_out32;
            3'd1: w_rd = w_dir32;
            3'd2: w_rd = w_in32;
`ifdef GPIO_IRQ_EN
            3'd5: w_rd = w_mask32;
            3'd6: w_rd = w_status32;
            3'd7: w_rd = w_edge32;
`endif
            default: w_rd = '0;
        endcase
    end

    // Bus handshake: capture read data on acceptance, pulse ready for one cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= StIdle;
            r_ready <= 1'b0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (mem_valid) begin
                        r_state <= StAck;
                        r_ready <= 1'b1;
                        r_rdata <= w_rd;
                    end else begin
                        r_ready <= 1'b0;
                        r_rdata <= '0;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_ready <= 1'b0;
                    r_rdata <= '0;
                end
            endcase
        end
    end

    // Output data, direction and the input synchronizer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_data_out <= OUT_RESET[NGPIO-1:0];
            r_dir      <= '0;
            r_sync1    <= '0;
            r_sync2    <= '0;
        end else begin
            r_data_out <= w_out_nxt[NGPIO-1:0];
            r_dir      <= w_dir_nxt[NGPIO-1:0];
            r_sync1    <= gpio_in;
            r_sync2    <= r_sync1;
        end
    end

`ifdef GPIO_IRQ_EN
    assign w_event = (r_irq_edge & r_sync2 & ~r_sync3) | (~r_irq_edge & ~r_sync2 & r_sync3);
    assign w_clr   = (w_wr && (w_off == 3'd6)) ? w_wval[NGPIO-1:0] : '0;

    // Edge detection and W1C status; a same-cycle event wins over the clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync3      <= '0;
            r_irq_mask   <= '0;
            r_irq_status <= '0;
            r_irq_edge   <= '0;
            r_irq        <= 1'b0;
        end else begin
            r_sync3      <= r_sync2;
            r_irq_mask   <= w_mask_nxt[NGPIO-1:0];
            r_irq_edge   <= w_edge_nxt[NGPIO-1:0];
            r_irq_status <= (r_irq_status & ~w_clr) | w_event;
            r_irq        <= |(r_irq_status & r_irq_mask);
        end
    end

    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif

    logic w_unused;
`ifdef GPIO_IRQ_EN
    assign w_unused = ^{mem_addr[31:5], mem_addr[1:0], w_out_nxt, w_dir_nxt,
                        w_mask_nxt, w_edge_nxt};
`else
    assign w_unused = ^{mem_addr[31:5], mem_addr[1:0], w_out_nxt, w_dir_nxt};
`endif

    assign mem_ready = r_ready;
    assign mem_rdata = r_rdata;
    assign gpio_out  = r_data_out;
    assign gpio_oe   = r_dir;

endmodule
